// File: rtl/icb_splt_dec.sv
// 1-to-N ICB splitter: address-decoded channel select, in-order responses via an
// outstanding counter plus current target, and a built-in decode-error slave.
module icb_splt_dec_hit #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW-1:0] msk_i,
  output logic          hit_o
);
  assign hit_o = ((addr_i & msk_i) == (base_i & msk_i));
endmodule

module icb_splt_dec #(
  parameter int                        AW              = 32,
  parameter int                        DW              = 64,
  parameter int                        USR_W           = 1,
  parameter int                        SPLT_NUM        = 4,
  parameter int                        OTF_W           = 3,
  parameter logic [SPLT_NUM*AW-1:0]    BASE_ADDR       = '0,
  parameter logic [SPLT_NUM*AW-1:0]    ADDR_MSK        = '0,
  parameter bit                        ALLOW_0CYCL_RSP = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_icb_cmd_vld,
  output logic                         i_icb_cmd_rdy,
  input  logic                         i_icb_cmd_read,
  input  logic [AW-1:0]                i_icb_cmd_addr,
  input  logic [DW-1:0]                i_icb_cmd_wdata,
  input  logic [DW/8-1:0]              i_icb_cmd_wmask,
  input  logic [USR_W-1:0]             i_icb_cmd_usr,
  output logic                         i_icb_rsp_vld,
  input  logic                         i_icb_rsp_rdy,
  output logic                         i_icb_rsp_err,
  output logic [DW-1:0]                i_icb_rsp_rdata,
  output logic [USR_W-1:0]             i_icb_rsp_usr,
  output logic [SPLT_NUM-1:0]          o_bus_icb_cmd_vld,
  input  logic [SPLT_NUM-1:0]          o_bus_icb_cmd_rdy,
  output logic [SPLT_NUM-1:0]          o_bus_icb_cmd_read,
  output logic [SPLT_NUM*AW-1:0]       o_bus_icb_cmd_addr,
  output logic [SPLT_NUM*DW-1:0]       o_bus_icb_cmd_wdata,
  output logic [SPLT_NUM*DW/8-1:0]     o_bus_icb_cmd_wmask,
  output logic [SPLT_NUM*USR_W-1:0]    o_bus_icb_cmd_usr,
  input  logic [SPLT_NUM-1:0]          o_bus_icb_rsp_vld,
  output logic [SPLT_NUM-1:0]          o_bus_icb_rsp_rdy,
  input  logic [SPLT_NUM-1:0]          o_bus_icb_rsp_err,
  input  logic [SPLT_NUM*DW-1:0]       o_bus_icb_rsp_rdata,
  input  logic [SPLT_NUM*USR_W-1:0]    o_bus_icb_rsp_usr,
  output logic [OTF_W-1:0]             otf_cnt,
  output logic                         dec_err,
  output logic [AW-1:0]                dec_err_addr,
  input  logic                         dec_err_clr
);
  localparam int               NT      = SPLT_NUM + 1;
  localparam logic [OTF_W-1:0] MAX_OTF = {OTF_W{1'b1}};

  logic [SPLT_NUM-1:0] hit;
  logic [NT-1:0]       sel, cur_sel_q, rsp_sel, rsp_vld_all;
  logic [OTF_W-1:0]    cnt_q, cnt_d;
  logic                dflt_vld_q, dec_err_q;
  logic [USR_W-1:0]    dflt_usr_q;
  logic [AW-1:0]       dec_err_addr_q;
  logic                cnt_zero, is_dflt, otf_rsp_hs, dflt_drain, accept_ok, tgt_rdy;
  logic                cmd_hs, rsp_hs, dflt_cmd_hs, dflt_rsp_hs;

  for (genvar i = 0; i < SPLT_NUM; i++) begin : g_hit
    icb_splt_dec_hit #(.AW(AW)) u_hit (
      .addr_i (i_icb_cmd_addr),
      .base_i (BASE_ADDR[i*AW +: AW]),
      .msk_i  (ADDR_MSK[i*AW +: AW]),
      .hit_o  (hit[i])
    );
  end

  // Lowest-index hit wins; no hit falls through to the default slave.
  always_comb begin
    sel = '0;
    sel[SPLT_NUM] = 1'b1;
    for (int i = SPLT_NUM - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

  assign is_dflt     = sel[SPLT_NUM];
  assign cnt_zero    = (cnt_q == '0);
  assign rsp_vld_all = {dflt_vld_q, o_bus_icb_rsp_vld};
  // Response retiring an outstanding txn; frees a slot for a same-cycle command.
  assign otf_rsp_hs  = ~cnt_zero & i_icb_rsp_rdy & |(rsp_vld_all & cur_sel_q);
  assign dflt_drain  = otf_rsp_hs & cur_sel_q[SPLT_NUM];
  assign accept_ok   = (cnt_zero | (sel == cur_sel_q)) & ((cnt_q != MAX_OTF) | otf_rsp_hs)
                     & (~is_dflt | ~dflt_vld_q | dflt_drain);
  assign tgt_rdy     = |(sel & {1'b1, o_bus_icb_cmd_rdy});
  assign i_icb_cmd_rdy = accept_ok & tgt_rdy;
  assign cmd_hs      = i_icb_cmd_vld & i_icb_cmd_rdy;
  assign dflt_cmd_hs = cmd_hs & is_dflt;

  assign o_bus_icb_cmd_vld   = sel[SPLT_NUM-1:0] & {SPLT_NUM{i_icb_cmd_vld & accept_ok}};
  assign o_bus_icb_cmd_read  = {SPLT_NUM{i_icb_cmd_read}};
  assign o_bus_icb_cmd_addr  = {SPLT_NUM{i_icb_cmd_addr}};
  assign o_bus_icb_cmd_wdata = {SPLT_NUM{i_icb_cmd_wdata}};
  assign o_bus_icb_cmd_wmask = {SPLT_NUM{i_icb_cmd_wmask}};
  assign o_bus_icb_cmd_usr   = {SPLT_NUM{i_icb_cmd_usr}};

  always_comb begin
    rsp_sel = '0;
    if (!cnt_zero)                    rsp_sel = cur_sel_q;
    else if (ALLOW_0CYCL_RSP && cmd_hs) rsp_sel = sel;
  end

  assign o_bus_icb_rsp_rdy = {SPLT_NUM{i_icb_rsp_rdy}} & rsp_sel[SPLT_NUM-1:0];

  always_comb begin
    i_icb_rsp_vld   = |(rsp_vld_all & rsp_sel);
    i_icb_rsp_err   = rsp_sel[SPLT_NUM];
    i_icb_rsp_rdata = '0;
    i_icb_rsp_usr   = dflt_usr_q & {USR_W{rsp_sel[SPLT_NUM]}};
    for (int i = 0; i < SPLT_NUM; i++) begin
      i_icb_rsp_err   = i_icb_rsp_err | (o_bus_icb_rsp_err[i] & rsp_sel[i]);
      i_icb_rsp_rdata = i_icb_rsp_rdata | (o_bus_icb_rsp_rdata[i*DW +: DW] & {DW{rsp_sel[i]}});
      i_icb_rsp_usr   = i_icb_rsp_usr | (o_bus_icb_rsp_usr[i*USR_W +: USR_W] & {USR_W{rsp_sel[i]}});
    end
  end

  assign rsp_hs      = i_icb_rsp_vld & i_icb_rsp_rdy;
  assign dflt_rsp_hs = rsp_hs & rsp_sel[SPLT_NUM];

  always_comb begin
    cnt_d = cnt_q;
    if (cmd_hs && !rsp_hs)      cnt_d = cnt_q + 1'b1;
    else if (!cmd_hs && rsp_hs) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      cur_sel_q      <= '0;
      dflt_vld_q     <= 1'b0;
      dflt_usr_q     <= '0;
      dec_err_q      <= 1'b0;
      dec_err_addr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (cmd_hs) cur_sel_q <= sel;
      if (dflt_cmd_hs) begin
        dflt_vld_q <= 1'b1;
        dflt_usr_q <= i_icb_cmd_usr;
      end else if (dflt_rsp_hs) begin
        dflt_vld_q <= 1'b0;
      end
      // A new error in the clear cycle re-arms the flag and captures its address.
      if (dflt_cmd_hs && (!dec_err_q || dec_err_clr)) begin
        dec_err_q      <= 1'b1;
        dec_err_addr_q <= i_icb_cmd_addr;
      end else if (dec_err_clr) begin
        dec_err_q <= 1'b0;
      end
    end
  end

  assign otf_cnt      = cnt_q;
  assign dec_err      = dec_err_q;
  assign dec_err_addr = dec_err_addr_q;
endmodule
